// File: rtl/usb3_pkg.sv
// Shared definitions for the FT601 245-mode read path: bus widths, line geometry
// and the read sequencer state encoding.
package usb3_pkg;

    localparam int FT_DATA_W  = 32;
    localparam int LINE_WORDS = 40;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OE      = 2'd1,
        ST_READ    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Active-low bus strobes {oe_n, rd_n} that belong to a given state.
    function automatic logic [1:0] bus_strobes(input state_t st);
        logic [1:0] strobes;
        strobes = 2'b11;
        case (st)
            ST_OE:   strobes = 2'b01;
            ST_READ: strobes = 2'b00;
            default: strobes = 2'b11;
        endcase
        return strobes;
    endfunction

endpackage

// File: rtl/usb3_line_counter.sv
// Modulo-LINE_WORDS word counter; wrap pulses in the same cycle as the count
// returns to zero, i.e. together with the write that completes a line.
module usb3_line_counter #(
    parameter int LINE_WORDS = 40,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (inc) begin
                if (count == LAST) begin
                    count <= '0;
                    wrap  <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ft601_rx_ctrl.sv
// FT601 245 synchronous FIFO read sequencer: drives OE_N/RD_N, captures bus words
// into the downstream line FIFO under almost-full backpressure, and tracks lines.
module ft601_rx_ctrl #(
    parameter int DATA_W     = usb3_pkg::FT_DATA_W,
    parameter int LINE_WORDS = usb3_pkg::LINE_WORDS,
    parameter int CNT_W      = 6
) (
    input  logic              ftdi_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              rxf_n,
    input  logic [DATA_W-1:0] usb3_data_in,
    output logic              oe_n,
    output logic              rd_n,
    input  logic              fifo_afull,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic [CNT_W-1:0]  word_in_line,
    output logic              line_done,
    output logic              overflow_err,
    output logic              busy
);

    import usb3_pkg::*;

    state_t state;
    state_t nxt;
    logic   go;
    logic   cap;
    logic   wr_ok;

    // A burst may start or continue only while the chip has data, we are
    // enabled and the FIFO still has margin.
    assign go    = enable && !rxf_n && !fifo_afull;
    assign cap   = !rd_n && !rxf_n;
    assign wr_ok = cap && !fifo_full;
    assign busy  = (state != ST_IDLE);

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:    if (go) nxt = ST_OE;
            ST_OE:      nxt = go ? ST_READ : ST_RELEASE;
            ST_READ:    nxt = go ? ST_READ : ST_RELEASE;
            ST_RELEASE: nxt = ST_IDLE;
            default:    nxt = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so a stop condition seen on an
    // edge releases the bus right after that edge.
    always_ff @(posedge ftdi_clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            oe_n         <= 1'b1;
            rd_n         <= 1'b1;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            overflow_err <= 1'b0;
        end else begin
            state         <= nxt;
            {oe_n, rd_n}  <= bus_strobes(nxt);
            fifo_wr_en    <= wr_ok;
            if (wr_ok) begin
                fifo_wr_data <= usb3_data_in;
            end
            if (cap && fifo_full) begin
                overflow_err <= 1'b1;
            end
        end
    end

    usb3_line_counter #(
        .LINE_WORDS (LINE_WORDS),
        .CNT_W      (CNT_W)
    ) u_line_counter (
        .clk   (ftdi_clk),
        .rst_n (reset_n),
        .inc   (wr_ok),
        .count (word_in_line),
        .wrap  (line_done)
    );

endmodule

// File: tb/tb_ft601_rx_ctrl.sv
// Scoreboard bench for ft601_rx_ctrl: an FT601 source model feeds directed words,
// expected FIFO writes are queued at load time and checked by a separate monitor.
module tb_ft601_rx_ctrl;

    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 40;
    localparam int CNT_W      = 6;

    logic              ftdi_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic              rxf_n = 1'b1;
    logic [DATA_W-1:0] usb3_data_in = '0;
    logic              fifo_afull = 1'b0;
    logic              fifo_full = 1'b0;
    logic              oe_n;
    logic              rd_n;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic [CNT_W-1:0]  word_in_line;
    logic              line_done;
    logic              overflow_err;
    logic              busy;

    ft601_rx_ctrl #(
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS),
        .CNT_W      (CNT_W)
    ) dut (
        .ftdi_clk     (ftdi_clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .rxf_n        (rxf_n),
        .usb3_data_in (usb3_data_in),
        .oe_n         (oe_n),
        .rd_n         (rd_n),
        .fifo_afull   (fifo_afull),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .word_in_line (word_in_line),
        .line_done    (line_done),
        .overflow_err (overflow_err),
        .busy         (busy)
    );

    always #5 ftdi_clk = ~ftdi_clk;

    typedef struct {
        logic [31:0] data;
        bit          full;
    } chip_word_t;

    typedef struct {
        logic [31:0]      data;
        logic             done;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    chip_word_t chip_q[$];
    exp_t       exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int exp_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Queue a word in the source; unless it is flagged to meet a full FIFO,
    // also queue the write it must produce, with the hand-tracked line position.
    task automatic load(input logic [31:0] d, input bit full);
        chip_word_t w;
        exp_t       e;
        w.data = d;
        w.full = full;
        chip_q.push_back(w);
        if (!full) begin
            exp_cnt = (exp_cnt + 1) % LINE_WORDS;
            e.data  = d;
            e.done  = (exp_cnt == 0);
            e.cnt   = CNT_W'(exp_cnt);
            exp_q.push_back(e);
        end
    endtask

    task automatic cy();
        @(posedge ftdi_clk);
        #2;
    endtask

    task automatic wait_writes(input int target, input string name);
        int k;
        k = 0;
        while (wr_cnt < target && k < 500) begin
            cy();
            k++;
        end
        chk(name, 32'(wr_cnt >= target), 32'd1);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || chip_q.size() != 0 || busy !== 1'b0) && k < 500) begin
            cy();
            k++;
        end
        chk(name, 32'(exp_q.size() == 0 && chip_q.size() == 0 && busy === 1'b0), 32'd1);
    endtask

    // FT601 source: a word leaves the chip when the previous edge saw RD_N and
    // RXF_N both low; inputs change on the falling edge.
    logic rd_s  = 1'b1;
    logic rxf_s = 1'b1;
    always @(negedge ftdi_clk) begin
        if (reset_n && !rd_s && !rxf_s && chip_q.size() > 0) begin
            chip_q.delete(0);
        end
        if (chip_q.size() > 0) begin
            rxf_n        = 1'b0;
            usb3_data_in = chip_q[0].data;
            fifo_full    = chip_q[0].full;
        end else begin
            rxf_n     = 1'b1;
            fifo_full = 1'b0;
        end
        rd_s  = rd_n;
        rxf_s = rxf_n;
    end

    // Monitor: every FIFO write must match the head of the expected queue.
    always @(negedge ftdi_clk) begin
        exp_t e;
        if (fifo_wr_en === 1'b1) begin
            wr_cnt++;
            if (line_done === 1'b1) done_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got data 0x%0h, required no write", fifo_wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_data", fifo_wr_data, e.data);
                chk("line_done", 32'(line_done), 32'(e.done));
                chk("word_in_line", 32'(word_in_line), 32'(e.cnt));
            end
        end else if (line_done !== 1'b0) begin
            chk("line_done_no_write", 32'(line_done), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int nw;
        enable     = 1'b1;
        fifo_afull = 1'b0;
        cy();
        cy();
        chk("rst_oe_n", 32'(oe_n), 32'd1);
        chk("rst_rd_n", 32'(rd_n), 32'd1);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_wr_data", fifo_wr_data, 32'd0);
        chk("rst_word_in_line", 32'(word_in_line), 32'd0);
        chk("rst_line_done", 32'(line_done), 32'd0);
        chk("rst_overflow", 32'(overflow_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        cy();

        // Single word: OE then READ, one capture, RELEASE, IDLE.
        load(32'hA5A5_0001, 1'b0);
        cy();
        chk("sw_oe_fall", 32'(oe_n), 32'd0);
        chk("sw_rd_still_high", 32'(rd_n), 32'd1);
        cy();
        chk("sw_rd_fall", 32'(rd_n), 32'd0);
        chk("sw_oe_held", 32'(oe_n), 32'd0);
        cy();
        chk("sw_wr_en", 32'(fifo_wr_en), 32'd1);
        cy();
        chk("sw_release_oe", 32'(oe_n), 32'd1);
        chk("sw_release_rd", 32'(rd_n), 32'd1);
        chk("sw_release_busy", 32'(busy), 32'd1);
        cy();
        chk("sw_idle_busy", 32'(busy), 32'd0);
        chk("sw_word_in_line", 32'(word_in_line), 32'd1);
        chk("sw_writes", 32'(wr_cnt), 32'd1);

        reset_n = 1'b0;
        cy();
        chk("mid_rst_count", 32'(word_in_line), 32'd0);
        exp_cnt = 0;
        reset_n = 1'b1;
        cy();

        // Full line of 40 incrementing words.
        for (int i = 0; i < LINE_WORDS; i++) load(32'(i), 1'b0);
        drain("line_drain");
        chk("line_writes", 32'(wr_cnt), 32'd41);
        chk("line_done_count", 32'(done_cnt), 32'd1);
        chk("line_wrap", 32'(word_in_line), 32'd0);

        // Backpressure after word 10.
        base = wr_cnt;
        for (int i = 0; i < 20; i++) load(32'h100 + 32'(i), 1'b0);
        wait_writes(base + 10, "bp_reach10");
        fifo_afull = 1'b1;
        cy();
        chk("bp_oe_rise", 32'(oe_n), 32'd1);
        chk("bp_rd_rise", 32'(rd_n), 32'd1);
        repeat (4) cy();
        nw = wr_cnt;
        chk("bp_extra", 32'(nw), 32'(base + 12));
        chk("bp_idle", 32'(busy), 32'd0);
        repeat (4) cy();
        chk("bp_no_idle_write", 32'(wr_cnt), 32'(nw));
        chk("bp_idle_oe", 32'(oe_n), 32'd1);
        fifo_afull = 1'b0;
        cy();
        chk("bp_restart_oe", 32'(oe_n), 32'd0);
        chk("bp_restart_rd_high", 32'(rd_n), 32'd1);
        cy();
        chk("bp_restart_rd", 32'(rd_n), 32'd0);
        drain("bp_drain");
        chk("bp_total", 32'(wr_cnt), 32'(base + 20));

        // Overflow: one word captured while the FIFO reports full.
        chk("ovf_clear_before", 32'(overflow_err), 32'd0);
        base = wr_cnt;
        load(32'h200, 1'b0);
        load(32'h201, 1'b0);
        load(32'h202, 1'b1);
        load(32'h203, 1'b0);
        load(32'h204, 1'b0);
        drain("ovf_drain");
        chk("ovf_set", 32'(overflow_err), 32'd1);
        chk("ovf_writes", 32'(wr_cnt), 32'(base + 4));
        chk("ovf_count", 32'(word_in_line), 32'd24);

        // Enable drop mid-READ.
        base = wr_cnt;
        for (int i = 0; i < 20; i++) load(32'h300 + 32'(i), 1'b0);
        wait_writes(base + 5, "en_reach5");
        enable = 1'b0;
        cy();
        chk("en_oe_rise", 32'(oe_n), 32'd1);
        chk("en_rd_rise", 32'(rd_n), 32'd1);
        chk("en_release_busy", 32'(busy), 32'd1);
        cy();
        chk("en_idle_busy", 32'(busy), 32'd0);
        repeat (5) cy();
        chk("en_no_burst_busy", 32'(busy), 32'd0);
        chk("en_no_burst_oe", 32'(oe_n), 32'd1);
        chk("en_writes", 32'(wr_cnt), 32'(base + 7));
        enable = 1'b1;
        drain("en_drain");
        chk("en_total", 32'(wr_cnt), 32'(base + 20));
        chk("ovf_sticky", 32'(overflow_err), 32'd1);
        chk("en_count", 32'(word_in_line), 32'd4);
        chk("en_done_count", 32'(done_cnt), 32'd2);

        // Asynchronous reset in the middle of READ.
        base = wr_cnt;
        for (int i = 0; i < 10; i++) load(32'h400 + 32'(i), 1'b0);
        wait_writes(base + 3, "ar_reach3");
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar_oe_n", 32'(oe_n), 32'd1);
        chk("ar_rd_n", 32'(rd_n), 32'd1);
        chk("ar_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("ar_word_in_line", 32'(word_in_line), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_overflow", 32'(overflow_err), 32'd0);
        chip_q.delete();
        exp_q.delete();
        exp_cnt = 0;
        cy();
        cy();
        reset_n = 1'b1;
        cy();
        cy();
        chk("ar_after_busy", 32'(busy), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
